// File: rtl/rx_hp_pkg.sv
// Shared types and constants for the RX huge-page allocator.
package rx_hp_pkg;

  typedef enum logic [4:0] {
    WAIT_PAGE = 5'b00001,
    OPEN      = 5'b00010,
    DRAIN     = 5'b00100,
    CLOSE     = 5'b01000,
    FREE      = 5'b10000
  } hp_state_e;

  typedef enum logic {
    PAGE1 = 1'b0,
    PAGE2 = 1'b1
  } page_sel_e;

  localparam int unsigned HDR_BYTES = 64;
  localparam int unsigned QW_BYTES  = 8;

endpackage

// File: rtl/rx_hp_idle_timer.sv
// Idle counter: counts enabled cycles, pulses expire on the last one and wraps.
// Latency: expire is combinational on the terminal count; no backpressure.
module rx_hp_idle_timer #(
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(IDLE_TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_huge_page_alloc.sv
// Owns the active huge page, grants packet write space, closes and returns pages.
// Latency: grant/err one cycle after the sampled request; pkt_req held by writer until answered.
module rx_huge_page_alloc
  import rx_hp_pkg::*;
#(
  parameter int unsigned PAGE_SIZE_LOG2 = 21,
  parameter int unsigned IDLE_TIMEOUT   = 1024
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] huge_page_addr_1,
  input  logic [63:0] huge_page_addr_2,
  input  logic        huge_page_status_1,
  input  logic        huge_page_status_2,
  output logic        huge_page_free_1,
  output logic        huge_page_free_2,
  input  logic        pkt_req,
  input  logic [8:0]  pkt_len_qw,
  output logic        pkt_gnt,
  output logic [63:0] pkt_addr,
  output logic        pkt_err,
  input  logic        pkt_done,
  output logic        close_req,
  output logic [63:0] close_addr,
  output logic [31:0] close_qw_count,
  input  logic        close_ack
);

  localparam int unsigned OW         = PAGE_SIZE_LOG2 + 1;
  localparam logic [31:0] PAGE_BYTES = 32'd1 << PAGE_SIZE_LOG2;
  localparam int unsigned QW_SHIFT   = $clog2(QW_BYTES);

  hp_state_e   state_q, state_d;
  page_sel_e   cur_q, cur_d;
  logic [OW-1:0] offset_q, offset_d;
  logic [63:0] base_q, base_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        outst_q, outst_d;

  logic        gnt_q, gnt_d;
  logic [63:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        close_req_q, close_req_d;
  logic [63:0] close_addr_q, close_addr_d;
  logic [31:0] close_cnt_q, close_cnt_d;
  logic        free1_q, free1_d;
  logic        free2_q, free2_d;

  logic [31:0] end_off;
  logic        fit;
  logic        outst_eff;
  logic        req_new;
  logic        grant;
  logic        status_cur;
  logic [63:0] addr_cur;
  logic        tmr_clr, tmr_en, tmr_expire;

  assign end_off    = 32'(offset_q) + 32'(pkt_len_qw) * QW_BYTES;
  assign fit        = (end_off <= PAGE_BYTES);
  assign outst_eff  = outst_q && !pkt_done;
  // The request visible while its grant/err pulse is out is the one just answered.
  assign req_new    = pkt_req && !gnt_q && !err_q;
  assign grant      = (state_q == OPEN) && req_new && !outst_eff && fit;
  assign status_cur = (cur_q == PAGE1) ? huge_page_status_1 : huge_page_status_2;
  assign addr_cur   = (cur_q == PAGE1) ? huge_page_addr_1 : huge_page_addr_2;

  assign tmr_clr = grant || (state_q != OPEN);
  assign tmr_en  = (state_q == OPEN) && !outst_q && (pkt_cnt_q != 16'd0) && !pkt_req;

  rx_hp_idle_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk_i    (trn_clk),
    .rst_ni   (reset_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    offset_d  = offset_q;
    base_d    = base_q;
    pkt_cnt_d = pkt_cnt_q;
    outst_d   = outst_q && !pkt_done;
    gnt_d     = 1'b0;
    addr_d    = '0;
    err_d     = 1'b0;

    unique case (state_q)
      WAIT_PAGE: begin
        if (status_cur) begin
          base_d    = addr_cur;
          offset_d  = OW'(HDR_BYTES);
          pkt_cnt_d = '0;
          state_d   = OPEN;
        end
      end
      OPEN: begin
        if (grant) begin
          gnt_d    = 1'b1;
          addr_d   = base_q + 64'(offset_q);
          offset_d = end_off[OW-1:0];
          outst_d  = 1'b1;
          if (pkt_cnt_q != 16'hFFFF) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end
        end else if (req_new && !fit) begin
          // Empty page can never hold it; otherwise retry on a fresh page.
          if (pkt_cnt_q == 16'd0) begin
            err_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else if (tmr_expire) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!outst_eff) begin
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (close_ack) begin
          state_d = FREE;
        end
      end
      FREE: begin
        cur_d   = (cur_q == PAGE1) ? PAGE2 : PAGE1;
        state_d = WAIT_PAGE;
      end
      default: begin
        state_d = WAIT_PAGE;
      end
    endcase

    close_req_d  = (state_d == CLOSE);
    close_addr_d = (state_d == CLOSE) ? base_q : 64'd0;
    close_cnt_d  = (state_d == CLOSE) ? 32'(offset_q >> QW_SHIFT) : 32'd0;
    free1_d      = (state_d == FREE) && (cur_q == PAGE1);
    free2_d      = (state_d == FREE) && (cur_q == PAGE2);
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_PAGE;
      cur_q        <= PAGE1;
      offset_q     <= OW'(HDR_BYTES);
      base_q       <= '0;
      pkt_cnt_q    <= '0;
      outst_q      <= 1'b0;
      gnt_q        <= 1'b0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      close_req_q  <= 1'b0;
      close_addr_q <= '0;
      close_cnt_q  <= '0;
      free1_q      <= 1'b0;
      free2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      offset_q     <= offset_d;
      base_q       <= base_d;
      pkt_cnt_q    <= pkt_cnt_d;
      outst_q      <= outst_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      close_req_q  <= close_req_d;
      close_addr_q <= close_addr_d;
      close_cnt_q  <= close_cnt_d;
      free1_q      <= free1_d;
      free2_q      <= free2_d;
    end
  end

  assign pkt_gnt          = gnt_q;
  assign pkt_addr         = addr_q;
  assign pkt_err          = err_q;
  assign close_req        = close_req_q;
  assign close_addr       = close_addr_q;
  assign close_qw_count   = close_cnt_q;
  assign huge_page_free_1 = free1_q;
  assign huge_page_free_2 = free2_q;

endmodule

// File: tb/tb_rx_huge_page_alloc.sv
// Bench for rx_huge_page_alloc: directed scenarios plus randomized traffic against a page/offset model.
module tb_rx_huge_page_alloc;

  localparam int     T  = 16;
  localparam longint PG = longint'(1) << 21;

  logic        trn_clk = 1'b0;
  logic        reset_n;
  logic [63:0] huge_page_addr_1, huge_page_addr_2;
  logic        huge_page_status_1, huge_page_status_2;
  logic        huge_page_free_1, huge_page_free_2;
  logic        pkt_req;
  logic [8:0]  pkt_len_qw;
  logic        pkt_gnt, pkt_err, pkt_done;
  logic [63:0] pkt_addr;
  logic        close_req, close_ack;
  logic [63:0] close_addr;
  logic [31:0] close_qw_count;

  logic [63:0] s_addr_1, s_addr_2;
  logic        s_status_1, s_status_2, s_free_1, s_free_2;
  logic        s_req, s_gnt, s_err, s_done, s_close_req, s_close_ack;
  logic [8:0]  s_len;
  logic [63:0] s_pkt_addr, s_close_addr;
  logic [31:0] s_close_cnt;

  always #5 trn_clk = ~trn_clk;

  rx_huge_page_alloc #(.PAGE_SIZE_LOG2(21), .IDLE_TIMEOUT(T)) dut (
    .trn_clk(trn_clk), .reset_n(reset_n),
    .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
    .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
    .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
    .pkt_req(pkt_req), .pkt_len_qw(pkt_len_qw), .pkt_gnt(pkt_gnt), .pkt_addr(pkt_addr),
    .pkt_err(pkt_err), .pkt_done(pkt_done), .close_req(close_req), .close_addr(close_addr),
    .close_qw_count(close_qw_count), .close_ack(close_ack)
  );

  rx_huge_page_alloc #(.PAGE_SIZE_LOG2(9), .IDLE_TIMEOUT(T)) dut_small (
    .trn_clk(trn_clk), .reset_n(reset_n),
    .huge_page_addr_1(s_addr_1), .huge_page_addr_2(s_addr_2),
    .huge_page_status_1(s_status_1), .huge_page_status_2(s_status_2),
    .huge_page_free_1(s_free_1), .huge_page_free_2(s_free_2),
    .pkt_req(s_req), .pkt_len_qw(s_len), .pkt_gnt(s_gnt), .pkt_addr(s_pkt_addr),
    .pkt_err(s_err), .pkt_done(s_done), .close_req(s_close_req), .close_addr(s_close_addr),
    .close_qw_count(s_close_cnt), .close_ack(s_close_ack)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the active page.
  int          mcur;      // 0 = page 1, 1 = page 2
  logic [63:0] mbase;
  longint      moff;
  int          mcnt;
  bit          mout;
  bit          use_next;
  logic [63:0] next_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic deliver_done();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    mout = 1'b0;
  endtask

  task automatic do_close(output longint cnt);
    int n;
    logic [63:0] na;
    n = 0;
    while (!close_req && n < 100) begin
      tick();
      n++;
    end
    chk("close_seen", close_req, 1'b1);
    chk("close_addr", close_addr, mbase);
    chk("close_cnt", close_qw_count, 64'(moff / 8));
    cnt = close_qw_count;
    repeat ($urandom_range(0, 3)) tick();
    chk("close_hold", close_req, 1'b1);
    close_ack = 1'b1;
    tick();
    close_ack = 1'b0;
    chk("free_pulse", {huge_page_free_1, huge_page_free_2}, (mcur == 0) ? 2'b10 : 2'b01);
    chk("close_drop", close_req, 1'b0);
    huge_page_status_1 = 1'b0;
    huge_page_status_2 = 1'b0;
    na = use_next ? next_addr : ({$urandom, $urandom} & ~64'h1F_FFFF);
    tick();
    chk("free_end", {huge_page_free_1, huge_page_free_2}, 2'b00);
    repeat ($urandom_range(0, 3)) tick();
    if (mcur == 0) begin
      huge_page_addr_2   = na;
      huge_page_status_2 = 1'b1;
    end else begin
      huge_page_addr_1   = na;
      huge_page_status_1 = 1'b1;
    end
    mcur  = 1 - mcur;
    mbase = na;
    moff  = 64;
    mcnt  = 0;
  endtask

  task automatic send_pkt(input int len, input int dly, input bit hold,
                          output logic [63:0] gaddr, output longint ccount);
    bit fit;
    int n;
    gaddr  = '0;
    ccount = -1;
    fit = (moff + longint'(len) * 8) <= PG;
    if (mout && fit) deliver_done();
    pkt_len_qw = 9'(len);
    pkt_req    = 1'b1;
    if (!fit) begin
      if (mout) begin
        for (int k = 0; k < 4; k++) begin
          tick();
          chk("drain_hold", close_req, 1'b0);
        end
        deliver_done();
      end
      do_close(ccount);
      n = 0;
      while (!pkt_gnt && n < 100) begin
        tick();
        n++;
      end
      chk("gnt_next_page", pkt_gnt, 1'b1);
    end else begin
      tick();
      chk("gnt_latency", pkt_gnt, 1'b1);
    end
    chk("gnt_addr", pkt_addr, mbase + 64'(moff));
    gaddr   = pkt_addr;
    pkt_req = 1'b0;
    moff += longint'(len) * 8;
    mcnt++;
    mout = 1'b1;
    tick();
    chk("gnt_pulse", pkt_gnt, 1'b0);
    repeat (dly) tick();
    if (!hold) deliver_done();
  endtask

  task automatic fill_to(input longint target);
    logic [63:0] ga;
    longint cc;
    longint rem;
    while (moff < target) begin
      rem = (target - moff) / 8;
      send_pkt((rem > 511) ? 511 : int'(rem), 0, 0, ga, cc);
    end
  endtask

  task automatic idle_close(output longint cnt);
    int n;
    bit timed;
    timed = mout;
    if (mout) deliver_done();
    n = 0;
    while (!close_req && n < 100) begin
      tick();
      n++;
    end
    if (timed) chk("idle_window", (n >= T && n <= T + 2), 1'b1);
    do_close(cnt);
    repeat (4) tick();
  endtask

  initial begin
    logic [63:0] ga;
    longint cc;
    int n;
    bit closed_seen;

    reset_n = 1'b0;
    huge_page_addr_1 = '0; huge_page_addr_2 = '0;
    huge_page_status_1 = 1'b0; huge_page_status_2 = 1'b0;
    pkt_req = 1'b0; pkt_len_qw = '0; pkt_done = 1'b0; close_ack = 1'b0;
    s_addr_1 = '0; s_addr_2 = '0; s_status_1 = 1'b0; s_status_2 = 1'b0;
    s_req = 1'b0; s_len = '0; s_done = 1'b0; s_close_ack = 1'b0;
    use_next = 1'b0; next_addr = '0;
    repeat (3) tick();
    chk("rst_flags", {pkt_gnt, pkt_err, close_req, huge_page_free_1, huge_page_free_2}, 5'b0);
    chk("rst_pkt_addr", pkt_addr, 64'd0);
    chk("rst_close_addr", close_addr, 64'd0);
    chk("rst_close_cnt", close_qw_count, 64'd0);

    // Basic grants on page 1.
    huge_page_addr_1   = 64'h0000_0001_0000_0000;
    huge_page_status_1 = 1'b1;
    reset_n = 1'b1;
    mcur = 0; mbase = huge_page_addr_1; moff = 64; mcnt = 0; mout = 1'b0;
    repeat (3) tick();
    send_pkt(4, 1, 0, ga, cc);
    chk("basic_first", ga, 64'h1_0000_0040);
    send_pkt(4, 0, 0, ga, cc);
    chk("basic_second", ga, 64'h1_0000_0060);

    // Full page: request that does not fit moves to page 2.
    fill_to(PG - 16);
    use_next = 1'b1;
    next_addr = 64'h2_0000_0000;
    send_pkt(4, 0, 0, ga, cc);
    use_next = 1'b0;
    chk("full_count", cc, 64'd262142);
    chk("full_next_addr", ga, 64'h2_0000_0040);

    // Exact fill, then a close that must wait for the outstanding packet.
    fill_to(PG - 32);
    send_pkt(4, 0, 1, ga, cc);
    chk("exact_addr", ga, 64'h2_0000_0000 + 64'h1F_FFE0);
    send_pkt(1, 0, 0, ga, cc);
    chk("exact_count", cc, 64'd262144);

    // Idle closes; an empty page must stay open.
    idle_close(cc);
    chk("idle_count_one", cc, 64'd9);
    closed_seen = 1'b0;
    for (int k = 0; k < 3 * T; k++) begin
      tick();
      if (close_req) closed_seen = 1'b1;
    end
    chk("empty_stays_open", closed_seen, 1'b0);
    send_pkt(2, 0, 1, ga, cc);
    idle_close(cc);
    chk("idle_count", cc, 64'd10);

    // Reset while a close is pending.
    send_pkt(3, 0, 0, ga, cc);
    n = 0;
    while (!close_req && n < 100) begin
      tick();
      n++;
    end
    chk("rstmid_close_seen", close_req, 1'b1);
    huge_page_addr_1 = 64'hA_0000_0000; huge_page_status_1 = 1'b1;
    huge_page_addr_2 = 64'hB_0000_0000; huge_page_status_2 = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rstmid_flags", {pkt_gnt, pkt_err, close_req, huge_page_free_1, huge_page_free_2}, 5'b0);
    chk("rstmid_close_addr", close_addr, 64'd0);
    chk("rstmid_close_cnt", close_qw_count, 64'd0);
    repeat (2) tick();
    chk("rstmid_no_free", {huge_page_free_1, huge_page_free_2}, 2'b00);
    reset_n = 1'b1;
    mcur = 0; mbase = 64'hA_0000_0000; moff = 64; mcnt = 0; mout = 1'b0;
    repeat (3) tick();
    send_pkt(2, 0, 0, ga, cc);
    chk("rstmid_page1", ga, 64'hA_0000_0040);

    // Randomized traffic.
    for (int i = 0; i < 1200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        send_pkt($urandom_range(1, 8), 0, 1, ga, cc);
        idle_close(cc);
      end else begin
        send_pkt((r < 80) ? 511 : $urandom_range(1, 511), $urandom_range(0, 3),
                 ($urandom_range(0, 9) == 0), ga, cc);
      end
    end
    if (mout) deliver_done();

    // Small page: error on empty page, exact fill, then close.
    s_addr_1 = 64'h3000_0000;
    s_status_1 = 1'b1;
    repeat (3) tick();
    s_req = 1'b1; s_len = 9'd63;
    tick();
    chk("small_err", s_err, 1'b1);
    chk("small_err_nognt", s_gnt, 1'b0);
    s_req = 1'b0;
    tick();
    chk("small_err_pulse", s_err, 1'b0);
    s_req = 1'b1; s_len = 9'd56;
    tick();
    chk("small_exact_gnt", s_gnt, 1'b1);
    chk("small_exact_addr", s_pkt_addr, 64'h3000_0040);
    s_req = 1'b0;
    tick();
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    s_req = 1'b1; s_len = 9'd1;
    n = 0;
    while (!s_close_req && n < 20) begin
      tick();
      n++;
    end
    chk("small_close", s_close_req, 1'b1);
    chk("small_close_cnt", s_close_cnt, 64'd64);
    chk("small_no_err", s_err, 1'b0);
    s_close_ack = 1'b1;
    tick();
    s_close_ack = 1'b0;
    chk("small_free", {s_free_1, s_free_2}, 2'b10);
    s_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
